pipe_control: RTL and testbench
===============================

// Module: pipe_control
// PURPOSE
//  Control unit driving the 5-stage datapath: decodes OpCode of the IF/ID instruction, registers the
//  control word through ID/EX, EX/MEM and MEM/WB so each stage gets signals of its own instruction,
//  detects load-use hazards (stall, one bubble), resolves branches in MEM (PCSrc, flush).
//  Sits beside datapath; its stage outputs drive the datapath control inputs.
// PARAMETERS
//  CNT_W  16  width of saturating stall/flush event counters
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  OpCode       in   6      Instruction[31:26] of instruction in IF/ID
//  id_rs        in   5      IF/ID instr[25:21]
//  id_rt        in   5      IF/ID instr[20:16]
//  ex_rt        in   5      rt of instruction in ID/EX
//  mem_Zero     in   1      ALU zero flag registered in EX/MEM
//  RegDst       out  1      EX-stage: write reg = rd (1) / rt (0)
//  AluSrc       out  1      EX-stage: ALU B = sign-extended imm (1) / rt (0)
//  ALUOp        out  4      EX-stage: 0000 add, 0001 sub, 0010 R-type(funct), 0011 or
//  MemRead      out  1      MEM-stage data memory read
//  MemWrite     out  1      MEM-stage data memory write
//  Branch       out  1      MEM-stage branch flag
//  MemtoReg     out  1      WB-stage: write data = memory (1) / ALU (0)
//  RegWrite     out  1      WB-stage register file write enable
//  PCSrc        out  1      Branch & mem_Zero: take branch target
//  PCWrite      out  1      0 = hold PC (stall)
//  IFIDWrite    out  1      0 = hold IF/ID (stall)
//  Flush        out  1      1 = zero IF/ID instruction (bubble)
//  stall_cnt    out  CNT_W  saturating count of stall cycles
//  flush_cnt    out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//  Decode (combinational, ID): 000000 R: RegDst,RegWrite,ALUOp=0010 | 100011 lw: AluSrc,MemRead,
//   MemtoReg,RegWrite,ALUOp=0000 | 101011 sw: AluSrc,MemWrite,ALUOp=0000 | 000100 beq: Branch,
//   ALUOp=0001 | 001000 addi: AluSrc,RegWrite,ALUOp=0000 | 001101 ori: AluSrc,RegWrite,ALUOp=0011 |
//   any other opcode: all-zero word (nop), no error.
//  Pipeline: ID/EX holds full word; EX/MEM holds MemRead,MemWrite,Branch,MemtoReg,RegWrite; MEM/WB
//   holds MemtoReg,RegWrite. Stage outputs come straight from those registers (1 cycle per stage).
//  Stall (comb.): ex_MemRead && ex_rt!=0 && (ex_rt==id_rs || (ex_rt==id_rt && OpCode in {R,sw,beq})).
//   On stall: PCWrite=0, IFIDWrite=0, all-zero word loaded into ID/EX; EX/MEM, MEM/WB advance.
//   Exactly one bubble per load-use pair (next cycle ex_MemRead=0).
//  Branch (comb.): PCSrc = mem Branch & mem_Zero. When PCSrc=1: Flush=1, and next edge loads zero
//   into ID/EX and the EX/MEM branch/mem/write bits (squash 3 younger instrs); MEM/WB advances.
//  Priority: PCSrc over stall; when both asserted, PCWrite=1, IFIDWrite=1, stall_cnt not incremented.
//  Not-taken beq (mem_Zero=0): no flush, no penalty.
//  Counters: +1 on each stall cycle / each PCSrc cycle; saturate at 2^CNT_W-1, no wrap.
//  Reset (async): all stage registers and counters 0 -> all stage outputs 0, PCSrc=0, Flush=0,
//   PCWrite=1, IFIDWrite=1. Reset mid-stall or mid-flush drops the event immediately; first
//   post-reset edge decodes the current OpCode normally.
// TESTING
//  1 Reset asserted mid-run, no clk edge -> all stage outputs 0, PCWrite=IFIDWrite=1, counters 0.
//  2 Stream lw, R, sw, beq, addi, ori, 111111 -> RegWrite/MemtoReg seen 3 cycles after each opcode
//    enters ID, MemRead/MemWrite/Branch 2 cycles, ALUOp 0000,0010,0000,0001,0000,0011, then all 0.
//  3 lw $2 then R-type rs=$2 -> one cycle PCWrite=0,IFIDWrite=0, bubble in EX, stall_cnt=1;
//    same with ex_rt=0 or addi rt=$2 -> no stall.
//  4 beq reaching MEM with mem_Zero=1 -> PCSrc=Flush=1 one cycle, next cycle EX/MEM MemWrite,
//    RegWrite=0 for squashed sw/R; flush_cnt=1. mem_Zero=0 -> no flush.
//  5 Branch taken same cycle as load-use stall -> PCWrite=1, stall_cnt unchanged, flush_cnt +1.
//  6 CNT_W=2, 5 stall events -> stall_cnt 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/pipe_control.sv
// Pipeline control unit: ID decode, control word carried through ID/EX, EX/MEM and MEM/WB,
// load-use stall detection and MEM-stage branch resolution with flush.
module pipe_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             mem_Zero,
  output logic             RegDst,
  output logic             AluSrc,
  output logic [3:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef struct packed {
    logic       RegDst;
    logic       AluSrc;
    logic [3:0] ALUOp;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       MemtoReg;
    logic       RegWrite;
  } ctrl_t;

  typedef struct packed {
    logic MemRead;
    logic MemWrite;
    logic Branch;
    logic MemtoReg;
    logic RegWrite;
  } mem_t;

  typedef struct packed {
    logic MemtoReg;
    logic RegWrite;
  } wb_t;

  ctrl_t r_idex;
  mem_t  r_exmem;
  wb_t   r_memwb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ctrl_t w_dec;
  logic  w_use_rt;
  logic  w_hazard;
  logic  w_pcsrc;
  logic  w_stall;

  always_comb begin
    w_dec = '0;
    case (OpCode)
      OP_R:    begin w_dec.RegDst = 1'b1; w_dec.RegWrite = 1'b1; w_dec.ALUOp = 4'b0010; end
      OP_LW:   begin
        w_dec.AluSrc   = 1'b1; w_dec.MemRead  = 1'b1;
        w_dec.MemtoReg = 1'b1; w_dec.RegWrite = 1'b1; w_dec.ALUOp = 4'b0000;
      end
      OP_SW:   begin w_dec.AluSrc = 1'b1; w_dec.MemWrite = 1'b1; w_dec.ALUOp = 4'b0000; end
      OP_BEQ:  begin w_dec.Branch = 1'b1; w_dec.ALUOp = 4'b0001; end
      OP_ADDI: begin w_dec.AluSrc = 1'b1; w_dec.RegWrite = 1'b1; w_dec.ALUOp = 4'b0000; end
      OP_ORI:  begin w_dec.AluSrc = 1'b1; w_dec.RegWrite = 1'b1; w_dec.ALUOp = 4'b0011; end
      default: w_dec = '0;
    endcase
  end

  // Only instructions that actually read rt can hit a load-use hazard through it.
  assign w_use_rt = (OpCode == OP_R) || (OpCode == OP_SW) || (OpCode == OP_BEQ);
  assign w_hazard = r_idex.MemRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && w_use_rt));
  assign w_pcsrc  = r_exmem.Branch && mem_Zero;
  // A taken branch squashes the hazarding pair anyway, so it wins over the stall.
  assign w_stall  = w_hazard && !w_pcsrc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex      <= '0;
      r_exmem     <= '0;
      r_memwb     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_memwb.MemtoReg <= r_exmem.MemtoReg;
      r_memwb.RegWrite <= r_exmem.RegWrite;
      if (w_pcsrc) begin
        r_idex  <= '0;
        r_exmem <= '0;
      end else begin
        r_exmem.MemRead  <= r_idex.MemRead;
        r_exmem.MemWrite <= r_idex.MemWrite;
        r_exmem.Branch   <= r_idex.Branch;
        r_exmem.MemtoReg <= r_idex.MemtoReg;
        r_exmem.RegWrite <= r_idex.RegWrite;
        r_idex           <= w_stall ? '0 : w_dec;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_pcsrc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign RegDst    = r_idex.RegDst;
  assign AluSrc    = r_idex.AluSrc;
  assign ALUOp     = r_idex.ALUOp;
  assign MemRead   = r_exmem.MemRead;
  assign MemWrite  = r_exmem.MemWrite;
  assign Branch    = r_exmem.Branch;
  assign MemtoReg  = r_memwb.MemtoReg;
  assign RegWrite  = r_memwb.RegWrite;
  assign PCSrc     = w_pcsrc;
  assign Flush     = w_pcsrc;
  assign PCWrite   = !w_stall;
  assign IFIDWrite = !w_stall;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decode stream, load-use stall, branch flush, priority,
// async reset and counter saturation (second instance with a 2-bit counter).
module tb_pipe_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       mem_Zero;

  logic        RegDst, AluSrc, MemRead, MemWrite, Branch, MemtoReg, RegWrite;
  logic        PCSrc, PCWrite, IFIDWrite, Flush;
  logic [3:0]  ALUOp;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_RegDst, s_AluSrc, s_MemRead, s_MemWrite, s_Branch, s_MemtoReg, s_RegWrite;
  logic        s_PCSrc, s_PCWrite, s_IFIDWrite, s_Flush;
  logic [3:0]  s_ALUOp;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .mem_Zero(mem_Zero), .RegDst(RegDst), .AluSrc(AluSrc), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Flush(Flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_control #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .OpCode(OpCode), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .mem_Zero(mem_Zero), .RegDst(s_RegDst), .AluSrc(s_AluSrc), .ALUOp(s_ALUOp),
    .MemRead(s_MemRead), .MemWrite(s_MemWrite), .Branch(s_Branch), .MemtoReg(s_MemtoReg),
    .RegWrite(s_RegWrite), .PCSrc(s_PCSrc), .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite),
    .Flush(s_Flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  logic [5:0] w_ex;
  logic [2:0] w_mem;
  logic [1:0] w_wb;
  assign w_ex  = {RegDst, AluSrc, ALUOp};
  assign w_mem = {MemRead, MemWrite, Branch};
  assign w_wb  = {MemtoReg, RegWrite};

  localparam logic [5:0] LW = 6'b100011, R = 6'b000000, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, PAD = 6'b111111;

  // Stream lw, R, sw, beq, addi, ori, 111111; index 7 is the idle (all-zero) word.
  logic [5:0] ops    [8] = '{LW, R, SW, BEQ, ADDI, ORI, PAD, PAD};
  logic [5:0] ex_tab [8] = '{6'b010000, 6'b100010, 6'b010000, 6'b000001,
                             6'b010000, 6'b010011, 6'b000000, 6'b000000};
  logic [2:0] mem_tab[8] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [1:0] wb_tab [8] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cl(input int j);
    return (j < 0 || j > 7) ? 7 : j;
  endfunction

  initial begin
    reset = 1'b1; OpCode = PAD; id_rs = '0; id_rt = '0; ex_rt = '0; mem_Zero = 1'b0;
    tick(); tick();
    chk("rst_ex", w_ex, 0);
    chk("rst_mem", w_mem, 0);
    chk("rst_wb", w_wb, 0);
    chk("rst_pcw", {PCWrite, IFIDWrite, PCSrc, Flush}, 4'b1100);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
    reset = 1'b0;

    // decode stream, no hazards
    for (int i = 0; i < 9; i++) begin
      OpCode = ops[cl(i)];
      tick();
      chk($sformatf("str_ex%0d", i), w_ex, ex_tab[cl(i)]);
      chk($sformatf("str_mem%0d", i), w_mem, mem_tab[cl(i - 1)]);
      chk($sformatf("str_wb%0d", i), w_wb, wb_tab[cl(i - 2)]);
      chk($sformatf("str_pcsrc%0d", i), PCSrc, 0);
    end

    // load-use stall: lw $2 then R rs=$2
    OpCode = LW; id_rs = 5'd0; id_rt = 5'd2; ex_rt = 5'd0;
    tick();
    ex_rt = 5'd2; OpCode = R; id_rs = 5'd2; id_rt = 5'd3;
    #1;
    chk("lu_pcw", {PCWrite, IFIDWrite, Flush}, 3'b000);
    tick();
    ex_rt = 5'd0;
    chk("lu_bubble_ex", w_ex, 0);
    chk("lu_lw_mem", w_mem, 3'b100);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_pcw_after", {PCWrite, IFIDWrite}, 2'b11);
    tick();
    chk("lu_r_ex", w_ex, 6'b100010);
    chk("lu_lw_wb", w_wb, 2'b11);
    // ex_rt = 0 never stalls
    OpCode = LW; id_rt = 5'd0;
    tick();
    OpCode = R; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    #1;
    chk("nz_pcw", {PCWrite, IFIDWrite}, 2'b11);
    // addi does not read rt
    OpCode = LW; id_rt = 5'd2;
    tick();
    ex_rt = 5'd2; OpCode = ADDI; id_rs = 5'd5; id_rt = 5'd2;
    #1;
    chk("addi_pcw", {PCWrite, IFIDWrite}, 2'b11);
    tick();
    chk("addi_cnt", stall_cnt, 1);

    // taken branch squashes sw (EX) and R (ID)
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    OpCode = BEQ; tick();
    OpCode = SW;  tick();
    mem_Zero = 1'b1; OpCode = R;
    #1;
    chk("br_pcsrc_flush", {PCSrc, Flush, PCWrite}, 3'b111);
    tick();
    mem_Zero = 1'b0; OpCode = PAD;
    chk("br_sq_mem", w_mem, 3'b000);
    chk("br_sq_ex", w_ex, 0);
    chk("br_fcnt", flush_cnt, 1);
    chk("br_pcsrc_off", {PCSrc, Flush}, 2'b00);
    tick();
    chk("br_sq_wb", w_wb, 2'b00);
    // not-taken branch
    OpCode = BEQ; tick();
    OpCode = PAD; tick();
    chk("nt_mem", w_mem, 3'b001);
    chk("nt_pcsrc", {PCSrc, Flush, PCWrite}, 3'b001);
    tick();
    chk("nt_fcnt", flush_cnt, 1);

    // taken branch coincides with load-use hazard
    OpCode = BEQ; tick();
    OpCode = LW; id_rt = 5'd4; tick();
    ex_rt = 5'd4; OpCode = R; id_rs = 5'd4; mem_Zero = 1'b1;
    #1;
    chk("pri_ctl", {PCSrc, PCWrite, IFIDWrite}, 3'b111);
    tick();
    mem_Zero = 1'b0; ex_rt = 5'd0;
    chk("pri_scnt", stall_cnt, 1);
    chk("pri_fcnt", flush_cnt, 2);

    // async reset between edges while a stall is pending
    OpCode = LW; id_rt = 5'd2; tick();
    ex_rt = 5'd2; OpCode = R; id_rs = 5'd2;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ex", w_ex, 0);
    chk("ar_mem_wb", {w_mem, w_wb}, 0);
    chk("ar_pcw", {PCWrite, IFIDWrite, PCSrc, Flush}, 4'b1100);
    chk("ar_cnt", {stall_cnt, flush_cnt, s_stall_cnt}, 0);
    OpCode = ORI; ex_rt = 5'd0;
    reset = 1'b0;
    tick();
    chk("ar_first_dec", w_ex, 6'b010011);

    // saturation on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      OpCode = LW; id_rs = 5'd0; id_rt = 5'd2; ex_rt = 5'd0;
      tick();
      ex_rt = 5'd2; OpCode = R; id_rs = 5'd2;
      tick();
      chk($sformatf("sat%0d", k), s_stall_cnt, (k + 1 > 3) ? 3 : k + 1);
    end
    chk("sat_wide", stall_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
